// File: rtl/gfx_cmd_scheduler.sv
// rtl/gfx_cmd_scheduler.sv - validating command FIFO feeding a graphics processor through a LOAD/RUN/RELEASE handshake
module gfx_cmd_scheduler #(
   parameter int DEPTH  = 4,
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_opcode,
   input  logic [9:0]  cmd_tl_x,
   input  logic [8:0]  cmd_tl_y,
   input  logic [9:0]  cmd_br_x,
   input  logic [8:0]  cmd_br_y,
   input  logic [11:0] cmd_arg,
   output logic        gp_en,
   output logic        gp_opcode,
   output logic [9:0]  gp_tl_x,
   output logic [8:0]  gp_tl_y,
   output logic [9:0]  gp_br_x,
   output logic [8:0]  gp_br_y,
   output logic [11:0] gp_arg,
   input  logic        gp_finish,
   input  logic        flush,
   output logic        busy,
   output logic [4:0]  cmd_count,
   output logic        done,
   output logic        reject,
   output logic [7:0]  reject_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_RELEASE} state_t;

   typedef struct packed {
      logic        opcode;
      logic [9:0]  tl_x;
      logic [8:0]  tl_y;
      logic [9:0]  br_x;
      logic [8:0]  br_y;
      logic [11:0] arg;
   } cmd_t;

   state_t          state_q, state_d;
   cmd_t            mem_q [DEPTH];
   cmd_t            mem_d [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [4:0]      count_q, count_d;
   cmd_t            gp_q, gp_d;
   logic            gp_en_q, gp_en_d;
   logic            first_q, first_d;
   logic            done_q, done_d;
   logic            reject_q, reject_d;
   logic [7:0]      reject_cnt_q, reject_cnt_d;
   logic            ready_q, ready_d;
   cmd_t            cmd_in;
   logic            bad, accept, push, pop;

   // ready_q holds cmd_ready low until the first edge out of reset
   assign cmd_ready = ready_q && (count_q < 5'(DEPTH)) && !flush;

   // next-state: validation, FIFO bookkeeping and the issue FSM
   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      gp_d         = gp_q;
      gp_en_d      = gp_en_q;
      first_d      = first_q;
      done_d       = 1'b0;
      reject_cnt_d = reject_cnt_q;
      ready_d      = 1'b1;
      cmd_in       = {cmd_opcode, cmd_tl_x, cmd_tl_y, cmd_br_x, cmd_br_y, cmd_arg};
      bad          = (cmd_tl_x > cmd_br_x) || (cmd_tl_y > cmd_br_y) ||
                     (int'(cmd_br_x) >= WIDTH) || (int'(cmd_br_y) >= HEIGHT);
      accept       = cmd_valid && cmd_ready;
      push         = accept && !bad;
      pop          = (state_q == S_LOAD);
      reject_d     = accept && bad;
      if (reject_d && reject_cnt_q != 8'hFF) reject_cnt_d = reject_cnt_q + 8'd1;
      if (push) begin
         mem_d[wr_ptr_q] = cmd_in;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + 5'(push) - 5'(pop);
      // flush drops queued entries only; the in-flight copy lives in gp_q
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
      case (state_q)
         S_IDLE: begin
            if (count_q != 5'd0 && !flush) state_d = S_LOAD;
         end
         S_LOAD: begin
            gp_d    = mem_q[rd_ptr_q];
            gp_en_d = 1'b1;
            first_d = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            first_d = 1'b0;
            if (!first_q && gp_finish) begin
               gp_en_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_RELEASE;
            end
         end
         default: begin
            state_d = (count_q != 5'd0 && !flush) ? S_LOAD : S_IDLE;
         end
      endcase
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         gp_q         <= '0;
         gp_en_q      <= 1'b0;
         first_q      <= 1'b0;
         done_q       <= 1'b0;
         reject_q     <= 1'b0;
         reject_cnt_q <= '0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         gp_q         <= gp_d;
         gp_en_q      <= gp_en_d;
         first_q      <= first_d;
         done_q       <= done_d;
         reject_q     <= reject_d;
         reject_cnt_q <= reject_cnt_d;
         ready_q      <= ready_d;
      end
   end

   assign gp_en      = gp_en_q;
   assign gp_opcode  = gp_q.opcode;
   assign gp_tl_x    = gp_q.tl_x;
   assign gp_tl_y    = gp_q.tl_y;
   assign gp_br_x    = gp_q.br_x;
   assign gp_br_y    = gp_q.br_y;
   assign gp_arg     = gp_q.arg;
   assign busy       = (state_q != S_IDLE);
   assign cmd_count  = count_q;
   assign done       = done_q;
   assign reject     = reject_q;
   assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_gfx_cmd_scheduler.sv
// tb/tb_gfx_cmd_scheduler.sv - directed self-checking bench for gfx_cmd_scheduler
module tb_gfx_cmd_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_opcode = 1'b0;
   logic [9:0]  cmd_tl_x = '0;
   logic [8:0]  cmd_tl_y = '0;
   logic [9:0]  cmd_br_x = '0;
   logic [8:0]  cmd_br_y = '0;
   logic [11:0] cmd_arg = '0;
   logic        gp_en, gp_opcode;
   logic [9:0]  gp_tl_x, gp_br_x;
   logic [8:0]  gp_tl_y, gp_br_y;
   logic [11:0] gp_arg;
   logic        gp_finish;
   logic        flush = 1'b0;
   logic        busy, done, reject;
   logic [4:0]  cmd_count;
   logic [7:0]  reject_cnt;

   int checks = 0;
   int errors = 0;

   gfx_cmd_scheduler dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_opcode(cmd_opcode), .cmd_tl_x(cmd_tl_x), .cmd_tl_y(cmd_tl_y),
      .cmd_br_x(cmd_br_x), .cmd_br_y(cmd_br_y), .cmd_arg(cmd_arg),
      .gp_en(gp_en), .gp_opcode(gp_opcode), .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y),
      .gp_br_x(gp_br_x), .gp_br_y(gp_br_y), .gp_arg(gp_arg), .gp_finish(gp_finish),
      .flush(flush), .busy(busy), .cmd_count(cmd_count), .done(done),
      .reject(reject), .reject_cnt(reject_cnt)
   );

   always #5 clk = ~clk;

   // graphics processor model: finish once gp_en has been high gp_lat edges
   int gp_lat = 8;
   int gp_cnt = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) gp_cnt <= 0;
      else gp_cnt <= gp_en ? gp_cnt + 1 : 0;
   end
   assign gp_finish = gp_en && (gp_cnt >= gp_lat);

   // monitor: issued commands, gaps, pulse counts, field stability
   logic [50:0] gp_word;
   assign gp_word = {gp_opcode, gp_tl_x, gp_tl_y, gp_br_x, gp_br_y, gp_arg};
   logic [50:0] got[$];
   int gaps[$];
   int rises = 0, dones = 0, rejects = 0, unstable = 0;
   int high_len = 0, last_high = 0, low_run = 0;
   logic prev_en = 1'b0;
   always @(negedge clk) begin
      if (gp_en && !prev_en) begin
         got.push_back(gp_word);
         rises++;
         if (rises > 1) gaps.push_back(low_run);
         high_len = 1;
      end else if (gp_en) begin
         high_len++;
         if (gp_word !== got[$]) unstable++;
      end
      if (prev_en && !gp_en) last_high = high_len;
      if (gp_en) low_run = 0; else low_run++;
      if (done) dones++;
      if (reject) rejects++;
      prev_en = gp_en;
   end

   function automatic logic [50:0] mk(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                                      input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
      return {op, tlx, tly, brx, bry, arg};
   endfunction

   // offer one command at a negedge; returns at the negedge after it transfers
   task automatic push(input logic op, input logic [9:0] tlx, input logic [8:0] tly,
                       input logic [9:0] brx, input logic [8:0] bry, input logic [11:0] arg);
      int n = 0;
      cmd_valid = 1'b1; cmd_opcode = op; cmd_tl_x = tlx; cmd_tl_y = tly;
      cmd_br_x = brx; cmd_br_y = bry; cmd_arg = arg;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         checks++; errors++;
         $display("FAIL push_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || cmd_count != 0) && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) begin
         checks++; errors++;
         $display("FAIL idle_timeout: busy %b cmd_count %0d, required 0 0", busy, cmd_count);
      end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic wait_gp_en();
      int n = 0;
      while (!gp_en && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         checks++; errors++;
         $display("FAIL gp_en_timeout: gp_en %b, required 1", gp_en);
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      checks++; if (gp_en !== 1'b0) begin errors++; $display("FAIL rst_gp_en: got %b exp 0", gp_en); end
      checks++; if (cmd_count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", cmd_count); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b exp 0", cmd_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      checks++; if (reject_cnt !== 8'd0) begin errors++; $display("FAIL rst_reject_cnt: got %0d exp 0", reject_cnt); end
      checks++; if ({done, reject, gp_arg} !== 14'd0) begin errors++; $display("FAIL rst_pulses: got %h exp 0", {done, reject, gp_arg}); end
      rst = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b exp 0", cmd_ready); end
      @(negedge clk);
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge: got %b exp 1", cmd_ready); end
   endtask

   task automatic test_single();
      int d0 = dones;
      gp_lat = 8;
      push(1'b0, 10'd0, 9'd0, 10'd3, 9'd1, 12'hF00);
      checks++; if (cmd_count !== 5'd1 || gp_en !== 1'b0) begin errors++; $display("FAIL single_queued: count %0d gp_en %b exp 1 0", cmd_count, gp_en); end
      @(negedge clk);
      checks++; if (busy !== 1'b1 || gp_en !== 1'b0) begin errors++; $display("FAIL single_load: busy %b gp_en %b exp 1 0", busy, gp_en); end
      @(negedge clk);
      checks++; if (gp_en !== 1'b1) begin errors++; $display("FAIL single_gp_en: got %b exp 1", gp_en); end
      checks++; if (gp_word !== mk(1'b0, 10'd0, 9'd0, 10'd3, 9'd1, 12'hF00))
         begin errors++; $display("FAIL single_fields: got %h exp %h", gp_word, mk(1'b0, 10'd0, 9'd0, 10'd3, 9'd1, 12'hF00)); end
      checks++; if (cmd_count !== 5'd0) begin errors++; $display("FAIL single_popped: got %0d exp 0", cmd_count); end
      wait_idle();
      checks++; if (last_high !== 9) begin errors++; $display("FAIL single_run_len: got %0d exp 9", last_high); end
      checks++; if (dones - d0 !== 1) begin errors++; $display("FAIL single_done: got %0d exp 1", dones - d0); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b exp 0", busy); end
   endtask

   task automatic test_first_cycle();
      gp_lat = 0;
      push(1'b1, 10'd1, 9'd2, 10'd3, 9'd4, 12'h055);
      wait_idle();
      checks++; if (last_high !== 2) begin errors++; $display("FAIL first_cycle_ignored: run len %0d exp 2", last_high); end
   endtask

   task automatic test_back_to_back();
      int gbase = gaps.size();
      int base = got.size();
      int d0 = dones;
      gp_lat = 3;
      for (int i = 0; i < 5; i++) push(i[0], 10'(i), 9'(i), 10'(i + 20), 9'(i + 10), 12'(12'h100 + i));
      checks++; if (cmd_count !== 5'd4 || cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: count %0d ready %b exp 4 0", cmd_count, cmd_ready); end
      wait_idle();
      checks++; if (got.size() - base !== 5) begin errors++; $display("FAIL b2b_issued: got %0d exp 5", got.size() - base); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got[base + i] !== mk(i[0], 10'(i), 9'(i), 10'(i + 20), 9'(i + 10), 12'(12'h100 + i)))
            begin errors++; $display("FAIL b2b_order[%0d]: got %h exp %h", i, got[base + i], mk(i[0], 10'(i), 9'(i), 10'(i + 20), 9'(i + 10), 12'(12'h100 + i))); end
      end
      for (int i = 1; i < 5; i++) begin
         checks++; if (gaps[gbase + i] !== 2) begin errors++; $display("FAIL b2b_gap[%0d]: got %0d exp 2", i, gaps[gbase + i]); end
      end
      checks++; if (dones - d0 !== 5) begin errors++; $display("FAIL b2b_done: got %0d exp 5", dones - d0); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL gp_stable: got %0d exp 0", unstable); end
   endtask

   task automatic test_reject();
      int r0 = rises;
      int j0 = rejects;
      push(1'b0, 10'd10, 9'd0, 10'd5, 9'd0, 12'h001);
      checks++; if (reject !== 1'b1 || cmd_count !== 5'd0) begin errors++; $display("FAIL reject_pulse: reject %b count %0d exp 1 0", reject, cmd_count); end
      push(1'b0, 10'd0, 9'd0, 10'd5, 9'd480, 12'h002);
      @(negedge clk); @(negedge clk);
      checks++; if (reject_cnt !== 8'd2) begin errors++; $display("FAIL reject_cnt2: got %0d exp 2", reject_cnt); end
      checks++; if (rejects - j0 !== 2) begin errors++; $display("FAIL reject_pulses: got %0d exp 2", rejects - j0); end
      checks++; if (rises - r0 !== 0) begin errors++; $display("FAIL reject_no_gp: got %0d exp 0", rises - r0); end
      push(1'b0, 10'd0, 9'd0, 10'd640, 9'd0, 12'h003);
      @(negedge clk);
      checks++; if (reject_cnt !== 8'd3) begin errors++; $display("FAIL reject_brx640: got %0d exp 3", reject_cnt); end
      for (int i = 0; i < 300; i++) push(1'b1, 10'd0, 9'd0, 10'd700, 9'd0, 12'h004);
      @(negedge clk);
      checks++; if (reject_cnt !== 8'd255) begin errors++; $display("FAIL reject_saturate: got %0d exp 255", reject_cnt); end
      gp_lat = 2;
      push(1'b0, 10'd0, 9'd0, 10'd639, 9'd479, 12'h0AB);
      wait_idle();
      checks++; if (rises - r0 !== 1 || got[$] !== mk(1'b0, 10'd0, 9'd0, 10'd639, 9'd479, 12'h0AB))
         begin errors++; $display("FAIL corner_accept: rises %0d cmd %h exp 1", rises - r0, got[$]); end
   endtask

   task automatic test_flush();
      int d0 = dones;
      int r0 = rises;
      gp_lat = 20;
      push(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h0A1);
      wait_gp_en();
      push(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h0B2);
      push(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h0C3);
      push(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h0D4);
      checks++; if (cmd_count !== 5'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", cmd_count); end
      flush = 1'b1;
      #1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b exp 0", cmd_ready); end
      @(negedge clk);
      flush = 1'b0;
      checks++; if (cmd_count !== 5'd0 || gp_en !== 1'b1) begin errors++; $display("FAIL flush_empty: count %0d gp_en %b exp 0 1", cmd_count, gp_en); end
      wait_idle();
      checks++; if (dones - d0 !== 1 || rises - r0 !== 1) begin errors++; $display("FAIL flush_inflight: done %0d rises %0d exp 1 1", dones - d0, rises - r0); end
      push(1'b0, 10'd1, 9'd1, 10'd2, 9'd2, 12'h0E5);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++; if (busy !== 1'b0 || cmd_count !== 5'd0 || rises - r0 !== 1)
         begin errors++; $display("FAIL flush_idle: busy %b count %0d rises %0d exp 0 0 1", busy, cmd_count, rises - r0); end
   endtask

   task automatic test_rst_mid_run();
      int d0;
      gp_lat = 50;
      push(1'b0, 10'd3, 9'd3, 10'd4, 9'd4, 12'h111);
      wait_gp_en();
      push(1'b0, 10'd3, 9'd3, 10'd4, 9'd4, 12'h222);
      push(1'b0, 10'd3, 9'd3, 10'd4, 9'd4, 12'h333);
      #2 rst = 1'b1;
      #1;
      checks++; if (gp_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_gp: gp_en %b busy %b exp 0 0", gp_en, busy); end
      checks++; if (cmd_count !== 5'd0 || cmd_ready !== 1'b0 || reject_cnt !== 8'd0)
         begin errors++; $display("FAIL rst_async_state: count %0d ready %b rcnt %0d exp 0 0 0", cmd_count, cmd_ready, reject_cnt); end
      @(negedge clk);
      rst = 1'b0;
      d0 = dones;
      gp_lat = 4;
      push(1'b1, 10'd5, 9'd6, 10'd7, 9'd8, 12'h444);
      wait_idle();
      checks++; if (got[$] !== mk(1'b1, 10'd5, 9'd6, 10'd7, 9'd8, 12'h444) || dones - d0 !== 1)
         begin errors++; $display("FAIL rst_recover: cmd %h done %0d exp 1", got[$], dones - d0); end
   endtask

   task automatic test_simul_push_pop();
      int base = got.size();
      gp_lat = 3;
      push(1'b0, 10'd8, 9'd8, 10'd9, 9'd9, 12'h5A5);
      @(negedge clk);
      push(1'b1, 10'd8, 9'd8, 10'd9, 9'd9, 12'h6B6);
      checks++; if (cmd_count !== 5'd1 || gp_en !== 1'b1 || gp_arg !== 12'h5A5)
         begin errors++; $display("FAIL simul_count: count %0d gp_en %b arg %h exp 1 1 5a5", cmd_count, gp_en, gp_arg); end
      wait_idle();
      checks++; if (got.size() - base !== 2 || got[base] !== mk(1'b0, 10'd8, 9'd8, 10'd9, 9'd9, 12'h5A5) ||
                    got[base + 1] !== mk(1'b1, 10'd8, 9'd8, 10'd9, 9'd9, 12'h6B6))
         begin errors++; $display("FAIL simul_order: n %0d first %h", got.size() - base, got[base]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_first_cycle();
      test_back_to_back();
      test_reject();
      test_flush();
      test_rst_mid_run();
      test_simul_push_pop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gfx_cmd_scheduler.md
GFX_CMD_SCHEDULER -- requirements
Module: gfx_cmd_scheduler

Interface
REQ-001 Parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..16).
REQ-002 Parameter WIDTH, default 640, meaning screen width in pixels used for command validation.
REQ-003 Parameter HEIGHT, default 480, meaning screen height in pixels used for command validation.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cmd_valid  in  1  requester offers a command.
REQ-007 cmd_ready  out  1  scheduler can accept; transfer when cmd_valid and cmd_ready at a rising edge.
REQ-008 cmd_opcode  in  1  0 = fill, 1 = draw from ROM.
REQ-009 cmd_tl_x/cmd_br_x  in  10  rectangle x corners, inclusive; cmd_tl_y/cmd_br_y  in  9  y corners, inclusive.
REQ-010 cmd_arg  in  12  fill colour or ROM base address.
REQ-011 gp_en  out  1  enable to graphics processor.
REQ-012 gp_opcode (1), gp_tl_x (10), gp_tl_y (9), gp_br_x (10), gp_br_y (9), gp_arg (12)  out  command fields to graphics processor, registered.
REQ-013 gp_finish  in  1  graphics processor completion flag.
REQ-014 flush  in  1  discard all queued (not in-flight) commands.
REQ-015 busy  out  1  a command is in flight (LOAD, RUN or RELEASE).
REQ-016 cmd_count  out  5  number of queued commands, 0..DEPTH.
REQ-017 done  out  1  one-cycle pulse per completed command.
REQ-018 reject  out  1  one-cycle pulse per rejected command.
REQ-019 reject_cnt  out  8  rejected-command count, saturating at 255.

Function
REQ-020 cmd_ready SHALL equal (cmd_count < DEPTH) and not flush; no same-cycle bypass of a full FIFO.
REQ-021 A transferred command SHALL be rejected (not queued, reject pulses the next cycle, reject_cnt +1 saturating) if tl_x > br_x, tl_y > br_y, br_x >= WIDTH or br_y >= HEIGHT; otherwise it is enqueued in arrival order.
REQ-022 FSM states IDLE, LOAD, RUN, RELEASE; gp_en = 1 only in RUN.
REQ-023 IDLE -> LOAD when cmd_count != 0 (count as registered before the edge).
REQ-024 LOAD: latch FIFO head into gp_* registers, pop it, -> RUN; gp_en rises the cycle after LOAD.
REQ-025 RUN: hold gp_en = 1 and gp_* stable; gp_finish ignored in the first RUN cycle; on gp_finish = 1 thereafter -> RELEASE.
REQ-026 RELEASE: gp_en = 0 for exactly one cycle, done = 1 in that cycle; -> LOAD if cmd_count != 0, else IDLE.
REQ-027 Minimum command-to-command gap: one gp_en-low cycle (RELEASE) plus one LOAD cycle.
REQ-028 Simultaneous enqueue and pop SHALL leave cmd_count unchanged and preserve order; pointers wrap modulo DEPTH.
REQ-029 flush SHALL empty the FIFO at the edge (cmd_count -> 0), takes priority over same-cycle enqueue, and SHALL NOT affect the in-flight command; if asserted in IDLE with queued entries, no LOAD occurs.
REQ-030 gp_finish while not in RUN SHALL be ignored.
REQ-031 busy = 1 in LOAD, RUN, RELEASE; 0 in IDLE.

Reset
REQ-032 While rst = 1, and immediately on assertion: state IDLE, gp_en 0, gp_* 0, FIFO empty, cmd_count 0, cmd_ready 0, done 0, reject 0, reject_cnt 0, busy 0.
REQ-033 rst mid-RUN SHALL drop gp_en without waiting for gp_finish; the in-flight and queued commands are lost.
REQ-034 cmd_ready SHALL be 1 from the first edge after rst deasserts.

Verification
REQ-035 Single fill (0,0)-(3,1), arg 0xF00, model finishes 8 cycles after gp_en rises -> gp_en high 2 cycles after accept, gp_* match, done one pulse, busy 0 after.
REQ-036 Push 5 valid commands back-to-back, DEPTH 4 -> cmd_ready low when 4 queued, all 5 issued in order, gp_en low exactly 2 cycles between commands.
REQ-037 Command tl_x=10, br_x=5, then br_y=480 -> two reject pulses, reject_cnt 2, gp_en never rises; 300 invalid -> reject_cnt 255.
REQ-038 Three queued during RUN, flush pulsed -> cmd_count 0, current command completes with done, then IDLE.
REQ-039 rst asserted mid-RUN with 2 queued -> gp_en 0 asynchronously, cmd_count 0; after release a new command executes normally.
REQ-040 Enqueue on the same edge as LOAD pop at cmd_count 1 -> cmd_count stays 1, order preserved.
